// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the 8-bit serial link (piso_tx sender, shift_reg receiver).
package serial_link_pkg;
  localparam int LINK_WIDTH = 8;

  typedef enum logic {IDLE, SHIFT} tx_state_t;
endpackage

// File: rtl/piso_hold.sv
// One-word holding register between the load handshake and the transmit shifter.
module piso_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             hold_full,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
    end else if (push) begin
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

  // Payload is qualified by hold_full, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one-word hold buffer feeding a shifter that
// emits one bit per enabled edge, with back-to-back reload so words stream without gaps.
module piso_tx
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             BTNC,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             push;
  logic             last;
  logic             do_load, do_step, do_end;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Bit that follows the one currently on serial_out, taken before shreg advances.
  function automatic logic next_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-2] : s[1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? (s << 1) : (s >> 1);
  endfunction

  // Acceptance needs an empty buffer and reload needs a full one, so they never coincide.
  assign push       = en && load_valid && !hold_full;
  assign load_ready = !hold_full;
  assign busy       = (state == SHIFT) || hold_full;
  assign last       = (cnt == CNT_LAST);

  piso_hold #(.WIDTH(WIDTH)) u_hold (
    .clk       (BTNC),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (do_load),
    .din       (load_data),
    .hold_full (hold_full),
    .dout      (hold_data)
  );

  always_ff @(posedge BTNC or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      unique case (state)
        IDLE:  if (hold_full)          state_nxt = SHIFT;
        SHIFT: if (last && !hold_full) state_nxt = IDLE;
        default:                       state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    do_load = 1'b0;
    do_step = 1'b0;
    do_end  = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: do_load = hold_full;
        SHIFT: begin
          if (last) begin
            do_end  = 1'b1;
            do_load = hold_full;
          end else begin
            do_step = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // done is rebuilt every edge so it is a single-cycle pulse even when en drops.
  always_ff @(posedge BTNC or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      shreg      <= '0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= do_end;
      if (do_load) begin
        shreg      <= hold_data;
        cnt        <= '0;
        serial_out <= first_bit(hold_data);
        bit_valid  <= 1'b1;
      end else if (do_step) begin
        shreg      <= shift_once(shreg);
        cnt        <= cnt + CNT_W'(1);
        serial_out <= next_bit(shreg);
      end else if (do_end) begin
        serial_out <= 1'b0;
        bit_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx with a looped-back LSB-first receiver model.
module tb_piso_tx;

  logic       BTNC = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       serial_out;
  logic       bit_valid;
  logic       busy;
  logic       done;
  logic [7:0] rx;

  int n_chk  = 0;
  int n_fail = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .BTNC       (BTNC),
    .reset_n    (reset_n),
    .en         (en),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 BTNC = ~BTNC;

  // Receiver: shifts in at the MSB end, enabled by en & bit_valid on the same clock.
  always_ff @(posedge BTNC) begin
    if (en && bit_valid) rx <= {serial_out, rx[7:1]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge BTNC);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    load_data  = w;
    load_valid = 1'b1;
    step();
    chk("ready_after_accept", 32'(load_ready), 32'd0);
    chk("busy_after_accept", 32'(busy), 32'd1);
    load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("bit", 32'(serial_out), 32'(w[k]));
      chk("bit_valid", 32'(bit_valid), 32'd1);
      chk("done_mid", 32'(done), 32'd0);
    end
    step();
    chk("done_end", 32'(done), 32'd1);
    chk("bit_valid_end", 32'(bit_valid), 32'd0);
    chk("serial_end", 32'(serial_out), 32'd0);
    chk("rx_word", 32'(rx), 32'(w));
    chk("busy_end", 32'(busy), 32'd0);
    step();
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    en         = 1'b1;
    load_data  = 8'h00;
    load_valid = 1'b0;
    rx         = 8'h00;
    #12;
    chk("rst_serial", 32'(serial_out), 32'd0);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    step();
    reset_n = 1'b1;
    step();

    // Single word, A5 = bits 1,0,1,0,0,1,0,1 from bit 0.
    send_word(8'hA5);

    // Reset in the middle of a word takes effect without a clock edge.
    load_data  = 8'hA5;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("pre_rst_bit_valid", 32'(bit_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_serial", 32'(serial_out), 32'd0);
    chk("mid_rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(bit_valid), 32'd0);
    send_word(8'h5A);

    // Back-to-back 3C then C3; C3 is offered while the buffer is full.
    load_data  = 8'h3C;
    load_valid = 1'b1;
    step();
    load_data = 8'hC3;
    chk("b2b_ready_full", 32'(load_ready), 32'd0);
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 1) chk("b2b_ready_after_reload", 32'(load_ready), 32'd1);
      if (e == 2) begin
        chk("b2b_accept_second", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
      end
      if (e <= 16) begin
        chk("b2b_bit_valid", 32'(bit_valid), 32'd1);
        chk("b2b_bit", 32'(serial_out),
            32'(((e <= 8) ? 8'h3C : 8'hC3) >> ((e - 1) % 8)) & 32'd1);
      end
      chk("b2b_done", 32'(done), 32'((e == 9) || (e == 17)));
      if (e == 9)  chk("b2b_rx_first", 32'(rx), 32'h3C);
      if (e == 17) begin
        chk("b2b_rx_second", 32'(rx), 32'hC3);
        chk("b2b_bit_valid_end", 32'(bit_valid), 32'd0);
      end
    end
    step();

    // Enable toggling 1,0,1,0 during 81: outputs freeze on disabled edges.
    load_data  = 8'h81;
    load_valid = 1'b1;
    en         = 1'b1;
    step();
    load_valid = 1'b0;
    begin
      int n = 0;
      for (int i = 0; i < 18; i++) begin
        en = (i % 2 == 0);
        step();
        if (en) n++;
        if (n >= 1 && n <= 8) begin
          chk("stall_bit", 32'(serial_out), 32'((8'h81 >> (n - 1)) & 8'h01));
          chk("stall_bit_valid", 32'(bit_valid), 32'd1);
        end
        chk("stall_done", 32'(done), 32'((n == 9) && en));
        if (n == 9) begin
          chk("stall_bit_valid_end", 32'(bit_valid), 32'd0);
          chk("stall_rx", 32'(rx), 32'h81);
        end
      end
    end
    en = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
